// File: rtl/estimulador_controladora.sv
// estimulador_controladora
// Stimulus generator that exercises a controller under test. It emulates a
// push-button or an IR sensor press of programmable length. After release it
// waits a settle time, then checks whether the controller led changed state
// as expected. Each command ends with an idle gap before the next is accepted.
//
// Ports
//   clk                single clock, rising edge
//   rst                synchronous reset, active low (0 = reset)
//   cmd_valid/ready    command handshake; cmd_ready is high only in IDLE
//   cmd_target         0 = push_button, 1 = infravermelho
//   cmd_dur            press length in cycles (0 = no press)
//   cmd_expect_toggle  1 = led is expected to change during the command
//   led_in             controller led under observation
//   push_button        emulated button line (registered)
//   infravermelho      emulated IR sensor line (registered)
//   done               one-cycle pulse marking the check cycle
//   pass               check verdict, qualified by done
module estimulador_controladora #(
  parameter int DUR_W        = 14,
  parameter int SAMPLE_DELAY = 5,
  parameter int GAP_CYCLES   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_target,
  input  logic [DUR_W-1:0] cmd_dur,
  input  logic             cmd_expect_toggle,
  input  logic             led_in,
  output logic             push_button,
  output logic             infravermelho,
  output logic             done,
  output logic             pass
);

  // The phase counter serves both SETTLE and GAP; it is loaded with
  // length-1, so it needs enough bits for the larger of the two minus one.
  localparam int PH_MAX = (SAMPLE_DELAY > GAP_CYCLES) ? SAMPLE_DELAY : GAP_CYCLES;
  localparam int PH_W   = (PH_MAX < 2) ? 1 : $clog2(PH_MAX);

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    SETTLE,
    CHECK,
    GAP
  } state_t;

  state_t           state_q;
  logic [DUR_W-1:0] dur_q;
  logic [PH_W-1:0]  ph_q;
  logic             target_q;
  logic             expect_q;
  logic             led_before_q;
  logic             push_q;
  logic             ir_q;
  logic             done_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      dur_q        <= '0;
      ph_q         <= '0;
      target_q     <= 1'b0;
      expect_q     <= 1'b0;
      led_before_q <= 1'b0;
      push_q       <= 1'b0;
      ir_q         <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            target_q     <= cmd_target;
            expect_q     <= cmd_expect_toggle;
            led_before_q <= led_in;
            if (cmd_dur != '0) begin
              // Line rises together with the state change so it is high
              // from the first cycle after the handshake.
              dur_q   <= cmd_dur;
              push_q  <= ~cmd_target;
              ir_q    <= cmd_target;
              state_q <= PRESS;
            end else begin
              dur_q   <= '0;
              ph_q    <= PH_W'(SAMPLE_DELAY - 1);
              state_q <= SETTLE;
            end
          end
        end

        PRESS: begin
          // dur_q holds the number of high cycles still to go including
          // the current one, so release when it reaches 1; never wraps.
          if (dur_q == DUR_W'(1)) begin
            push_q  <= 1'b0;
            ir_q    <= 1'b0;
            dur_q   <= '0;
            ph_q    <= PH_W'(SAMPLE_DELAY - 1);
            state_q <= SETTLE;
          end else begin
            push_q <= ~target_q;
            ir_q   <= target_q;
            dur_q  <= dur_q - DUR_W'(1);
          end
        end

        SETTLE: begin
          if (ph_q == '0) begin
            done_q  <= 1'b1;
            state_q <= CHECK;
          end else begin
            ph_q <= ph_q - PH_W'(1);
          end
        end

        CHECK: begin
          ph_q    <= PH_W'(GAP_CYCLES - 1);
          state_q <= GAP;
        end

        GAP: begin
          if (ph_q == '0) begin
            state_q <= IDLE;
          end else begin
            ph_q <= ph_q - PH_W'(1);
          end
        end

        default: begin
          push_q  <= 1'b0;
          ir_q    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready     = (state_q == IDLE) && rst;
  assign push_button   = push_q;
  assign infravermelho = ir_q;
  assign done          = done_q;
  // The verdict must reflect led_in during the check cycle itself, so it is
  // formed from the live input, gated by the registered done pulse.
  assign pass = done_q & (((led_in ^ led_before_q)) == expect_q);

endmodule

// File: tb/tb_estimulador_controladora.sv
module tb_estimulador_controladora;

  localparam int DUR_W = 14;
  localparam int SD    = 5;
  localparam int GAP   = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_target = 1'b0;
  logic [DUR_W-1:0] cmd_dur = '0;
  logic             cmd_expect_toggle = 1'b0;
  logic             led_in = 1'b0;
  logic             push_button;
  logic             infravermelho;
  logic             done;
  logic             pass;

  int checks   = 0;
  int failures = 0;

  // Measurements of one command, indexed by cycle after the handshake edge.
  int m_sel_cnt, m_oth_cnt, m_first, m_last, m_overlap, m_done_cnt;
  int m_done_cyc, m_pass, m_ready_cyc, m_stray_pass;
  int m_abort_lines, m_abort_ready, m_ready_after;

  estimulador_controladora #(
    .DUR_W(DUR_W), .SAMPLE_DELAY(SD), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_target(cmd_target), .cmd_dur(cmd_dur),
    .cmd_expect_toggle(cmd_expect_toggle), .led_in(led_in),
    .push_button(push_button), .infravermelho(infravermelho),
    .done(done), .pass(pass)
  );

  always #5 clk = ~clk;

  // Waits (bounded) for cmd_ready at a falling edge.
  task automatic wait_ready(input string name);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_wait_ready got=%b exp=1", name, cmd_ready);
    end
  endtask

  // Issues one command starting at a falling edge and records what the
  // lines do on each following cycle. rst_at>0 pulls reset at that cycle.
  task automatic run_cmd(input logic tgt, input int dur, input logic exp_t,
                         input int flip_at, input int valid_until,
                         input int rst_at, input int limit);
    logic sel, oth;
    bit   stop = 0;
    m_sel_cnt = 0; m_oth_cnt = 0; m_first = -1; m_last = -1; m_overlap = 0;
    m_done_cnt = 0; m_done_cyc = -1; m_pass = -1; m_ready_cyc = -1;
    m_stray_pass = 0; m_abort_lines = -1; m_abort_ready = -1; m_ready_after = -1;
    cmd_valid = 1'b1;
    cmd_target = tgt;
    cmd_dur = DUR_W'(dur);
    cmd_expect_toggle = exp_t;
    for (int c = 1; c <= limit && !stop; c++) begin
      @(negedge clk);
      sel = tgt ? infravermelho : push_button;
      oth = tgt ? push_button : infravermelho;
      if (sel) begin
        m_sel_cnt++;
        if (m_first < 0) m_first = c;
        m_last = c;
      end
      if (oth) m_oth_cnt++;
      if (push_button && infravermelho) m_overlap++;
      if (pass && !done) m_stray_pass++;
      if (done) begin
        m_done_cnt++;
        if (m_done_cyc < 0) begin
          m_done_cyc = c;
          m_pass = int'(pass);
        end
      end
      if (cmd_ready && m_ready_cyc < 0) m_ready_cyc = c;
      if (rst_at > 0 && c == rst_at + 2) m_ready_after = int'(cmd_ready);
      if (rst_at > 0 && c == rst_at + 1) begin
        m_abort_lines = int'(push_button | infravermelho);
        m_abort_ready = int'(cmd_ready);
        rst = 1'b1;
      end
      if (rst_at > 0 && c == rst_at) rst = 1'b0;
      if (c >= valid_until) cmd_valid = 1'b0;
      if (c == flip_at) led_in = ~led_in;
      if (rst_at <= 0 && m_ready_cyc > 0) stop = 1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({push_button, infravermelho, done, pass, cmd_ready} !== 5'b0) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d got=%b exp=00000", i,
                 {push_button, infravermelho, done, pass, cmd_ready});
      end
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got=%b exp=1", cmd_ready);
    end
    $display("reset: done");
  endtask

  task automatic test_long_press();
    wait_ready("long");
    run_cmd(1'b0, 5301, 1'b1, 2000, 1, 0, 6000);
    checks++;
    if (m_sel_cnt !== 5301 || m_first !== 1 || m_last !== 5301) begin
      failures++;
      $display("FAIL long_press_len got=%0d/%0d..%0d exp=5301/1..5301", m_sel_cnt, m_first, m_last);
    end
    checks++;
    if (m_done_cyc !== 5307 || m_pass !== 1) begin
      failures++;
      $display("FAIL long_done got=%0d pass=%0d exp=5307 pass=1", m_done_cyc, m_pass);
    end
    checks++;
    if (m_ready_cyc !== 5324) begin
      failures++;
      $display("FAIL long_ready got=%0d exp=5324", m_ready_cyc);
    end
    checks++;
    if (m_oth_cnt !== 0 || m_overlap !== 0) begin
      failures++;
      $display("FAIL long_other_line got=%0d overlap=%0d exp=0", m_oth_cnt, m_overlap);
    end
    $display("long_press: dur=5301 done=%0d pass=%0d ready=%0d", m_done_cyc, m_pass, m_ready_cyc);
  endtask

  task automatic test_threshold();
    for (int e = 0; e < 2; e++) begin
      wait_ready("threshold");
      run_cmd(1'b0, 5300, e[0], 0, 1, 0, 6000);
      checks++;
      if (m_sel_cnt !== 5300 || m_done_cyc !== 5306) begin
        failures++;
        $display("FAIL threshold_timing got=%0d done=%0d exp=5300 done=5306", m_sel_cnt, m_done_cyc);
      end
      checks++;
      if (m_pass !== (e == 0 ? 1 : 0)) begin
        failures++;
        $display("FAIL threshold_pass expect_toggle=%0d got=%0d exp=%0d", e, m_pass, (e == 0 ? 1 : 0));
      end
      $display("threshold: expect_toggle=%0d pass=%0d", e, m_pass);
    end
  endtask

  task automatic test_ir_zero();
    wait_ready("ir");
    run_cmd(1'b1, 3, 1'b0, 0, 1, 0, 200);
    checks++;
    if (m_sel_cnt !== 3 || m_first !== 1 || m_last !== 3 || m_oth_cnt !== 0) begin
      failures++;
      $display("FAIL ir_line got=%0d %0d..%0d push=%0d exp=3 1..3 push=0", m_sel_cnt, m_first, m_last, m_oth_cnt);
    end
    checks++;
    if (m_done_cyc !== 3 + 1 + SD || m_pass !== 1) begin
      failures++;
      $display("FAIL ir_done got=%0d pass=%0d exp=%0d pass=1", m_done_cyc, m_pass, 3 + 1 + SD);
    end
    $display("ir: dur=3 done=%0d pass=%0d", m_done_cyc, m_pass);
    wait_ready("zero");
    run_cmd(1'b0, 0, 1'b0, 0, 1, 0, 200);
    checks++;
    if (m_sel_cnt !== 0 || m_oth_cnt !== 0) begin
      failures++;
      $display("FAIL zero_lines got=%0d/%0d exp=0/0", m_sel_cnt, m_oth_cnt);
    end
    checks++;
    if (m_done_cyc !== 6 || m_ready_cyc !== 2 + SD + GAP) begin
      failures++;
      $display("FAIL zero_timing got=%0d ready=%0d exp=6 ready=%0d", m_done_cyc, m_ready_cyc, 2 + SD + GAP);
    end
    $display("zero: done=%0d ready=%0d", m_done_cyc, m_ready_cyc);
  endtask

  task automatic test_abuse();
    wait_ready("abuse");
    run_cmd(1'b0, 5301, 1'b0, 0, 50, 0, 6000);
    checks++;
    if (m_done_cnt !== 1 || m_sel_cnt !== 5301) begin
      failures++;
      $display("FAIL abuse_single_done got=%0d len=%0d exp=1 len=5301", m_done_cnt, m_sel_cnt);
    end
    $display("abuse_valid_held: dones=%0d", m_done_cnt);
    wait_ready("abort");
    run_cmd(1'b0, 5301, 1'b0, 0, 1, 100, 5500);
    checks++;
    if (m_sel_cnt !== 100 || m_abort_lines !== 0) begin
      failures++;
      $display("FAIL abort_lines got=%0d line_after=%0d exp=100 line_after=0", m_sel_cnt, m_abort_lines);
    end
    checks++;
    if (m_done_cnt !== 0) begin
      failures++;
      $display("FAIL abort_no_done got=%0d exp=0", m_done_cnt);
    end
    checks++;
    if (m_abort_ready !== 0 || m_ready_after !== 1) begin
      failures++;
      $display("FAIL abort_ready got=%0d/%0d exp=0/1", m_abort_ready, m_ready_after);
    end
    $display("abort: high=%0d dones=%0d ready_after=%0d", m_sel_cnt, m_done_cnt, m_ready_after);
  endtask

  // Random commands against a timing/verdict model derived from the rules:
  // line high for N cycles, done at N+1+SD, ready at N+2+SD+GAP, and
  // pass exactly when "led changed before the check" equals expect_toggle.
  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      logic tgt, ex;
      int   dur, mode, flip, exp_pass;
      tgt  = 1'($urandom_range(0, 1));
      ex   = 1'($urandom_range(0, 1));
      dur  = $urandom_range(0, 40);
      mode = $urandom_range(0, 2);  // 0 none, 1 before check, 2 after check
      flip = (mode == 1) ? $urandom_range(1, dur + SD) :
             (mode == 2) ? $urandom_range(dur + 2 + SD, dur + 1 + SD + GAP) : 0;
      exp_pass = ((mode == 1) == ex) ? 1 : 0;
      wait_ready("random");
      led_in = 1'($urandom_range(0, 1));
      run_cmd(tgt, dur, ex, flip, 1, 0, 200);
      checks++;
      if (m_sel_cnt !== dur || (dur > 0 && (m_first !== 1 || m_last !== dur)) ||
          m_oth_cnt !== 0 || m_overlap !== 0) begin
        failures++;
        $display("FAIL rand%0d_lines got=%0d %0d..%0d oth=%0d exp=%0d", i, m_sel_cnt, m_first, m_last, m_oth_cnt, dur);
      end
      checks++;
      if (m_done_cyc !== dur + 1 + SD || m_done_cnt !== 1 || m_pass !== exp_pass || m_stray_pass !== 0) begin
        failures++;
        $display("FAIL rand%0d_check got=%0d pass=%0d exp=%0d pass=%0d", i, m_done_cyc, m_pass, dur + 1 + SD, exp_pass);
      end
      checks++;
      if (m_ready_cyc !== dur + 2 + SD + GAP) begin
        failures++;
        $display("FAIL rand%0d_ready got=%0d exp=%0d", i, m_ready_cyc, dur + 2 + SD + GAP);
      end
      $display("random %0d: tgt=%0d dur=%0d exp=%0d mode=%0d pass=%0d", i, tgt, dur, ex, mode, m_pass);
    end
  endtask

  initial begin
    test_reset();
    test_long_press();
    test_threshold();
    test_ir_zero();
    test_abuse();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/estimulador_controladora.md
ESTIMULADOR_CONTROLADORA -- requirements
Module: estimulador_controladora

Interface
REQ-001 Parameter DUR_W, default 14: width of the press-duration field, in bits.
REQ-002 Parameter SAMPLE_DELAY, default 5: cycles from line release to the led check.
REQ-003 Parameter GAP_CYCLES, default 16: idle gap, in cycles, after each check.
REQ-004 The block SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 rst  in  1  synchronous reset, active-low (0 = reset).
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  command accept; a handshake occurs when cmd_valid=1 and cmd_ready=1 at a rising edge.
REQ-009 cmd_target  in  1  0 = drive push_button; 1 = drive infravermelho.
REQ-010 cmd_dur  in  DUR_W  press duration in cycles; 0 is legal.
REQ-011 cmd_expect_toggle  in  1  1 = the led is expected to change state.
REQ-012 led_in  in  1  controller led output, under observation.
REQ-013 push_button  out  1  emulated button line to the controller.
REQ-014 infravermelho  out  1  emulated IR sensor line to the controller.
REQ-015 done  out  1  one-cycle pulse that ends a command.
REQ-016 pass  out  1  check result; valid only while done=1, 0 otherwise.

Function
REQ-017 The block SHALL implement FSM states IDLE, PRESS, SETTLE, CHECK and GAP.
REQ-018 cmd_ready SHALL be 1 only in IDLE with rst=1.
REQ-019 On handshake, the block SHALL capture cmd_target, cmd_dur, cmd_expect_toggle and led_in (led_before).
REQ-020 Command inputs SHALL be ignored outside the handshake; cmd_valid while not in IDLE is dropped, with no queuing.
REQ-021 Handshake in cycle k with cmd_dur=N>0: go to PRESS.
  - The selected line is 1 in cycles k+1..k+N, exactly N cycles.
  - The selected line is 0 in cycle k+N+1.
REQ-022 Handshake with cmd_dur=0: go directly to SETTLE; no line is ever asserted.
REQ-023 The unselected line SHALL remain 0 for the entire command.
REQ-024 SETTLE SHALL last exactly SAMPLE_DELAY cycles with both lines 0.
REQ-025 CHECK SHALL last exactly one cycle, in cycle k+1+N+SAMPLE_DELAY for any N including 0.
  - done=1 during CHECK.
  - pass = ((led_in != led_before) == expect_toggle), evaluated from led_in in the CHECK cycle.
REQ-026 GAP SHALL last GAP_CYCLES cycles with cmd_ready=0 and both lines 0, then return to IDLE.
  - cmd_ready is therefore next 1 in cycle k+2+N+SAMPLE_DELAY+GAP_CYCLES.
REQ-027 The duration counter SHALL be DUR_W bits and SHALL count down from N without wrap-around.
  - N = 2^DUR_W-1 is supported exactly.
REQ-028 Outputs SHALL be registered and glitch-free, with push_button and infravermelho never 1 simultaneously.
REQ-029 Changes on led_in outside the handshake and CHECK cycles SHALL have no effect; only the final value matters.

Reset
REQ-030 While rst=0 at a rising edge, the block SHALL force:
  - state = IDLE;
  - push_button = 0, infravermelho = 0, done = 0, pass = 0;
  - counters = 0, captured fields = 0.
REQ-031 A reset during PRESS/SETTLE/CHECK/GAP SHALL abort the command.
  - Lines are 0 in the cycle after the reset edge.
  - No done pulse is produced for the aborted command.
REQ-032 cmd_ready SHALL be 0 while rst=0 and 1 in the first cycle after rst returns to 1.

Verification (SAMPLE_DELAY=5, GAP_CYCLES=16)
REQ-033 Reset: rst=0 for 3 cycles -> all outputs 0; cmd_ready=1 the cycle after release.
REQ-034 Long press: target=0, dur=5301, expect_toggle=1, bench flips led_in during the press.
  - push_button is high exactly 5301 cycles.
  - done at k+5307 with pass=1.
  - cmd_ready returns at k+5324.
REQ-035 Threshold press: target=0, dur=5300, led_in constant.
  - expect_toggle=0 -> pass=1.
  - Repeat with expect_toggle=1 -> pass=0.
REQ-036 IR and zero duration:
  - target=1, dur=3 -> infravermelho high 3 cycles, push_button stays 0.
  - dur=0 -> no line activity, done at k+6.
REQ-037 Abuse: cmd_valid held high during PRESS -> ignored, only one done.
  - rst=0 at cycle 100 of a 5301 press -> push_button 0 at the next edge, no done.
  - cmd_ready=1 after release.
